// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone B3 slave SRAM with byte-lane writes,
// programmable wait states, range error termination and incrementing bursts.
module wb_sram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_STATES = 0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic [31:0]             wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic [2:0]              wb_cti_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = (NB > 1) ? $clog2(NB) : 0;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] CTI_INCR = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BURST,
        S_ERR
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   beat_q, beat_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    req;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    out_of_range;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic                    rd_load;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    unused_adr;

    assign req          = wb_cyc_i & wb_stb_i;
    assign word_idx     = wb_adr_i[ADDR_WIDTH+LSB-1:LSB];
    assign out_of_range = |wb_adr_i[31:ADDR_WIDTH+LSB];
    // Byte-offset bits select nothing inside a word.
    assign unused_adr   = ^wb_adr_i;

    // ACK is a registered state; burst beats are qualified by strobe.
    assign wb_ack_o = wb_cyc_i &
                      ((state_q == S_ACK) |
                       ((state_q == S_BURST) & wb_stb_i));
    assign wb_err_o = wb_cyc_i & (state_q == S_ERR);
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = dat_q;

    assign wr_en = wb_ack_o & wb_we_i;

    // Merge enabled write lanes over the word currently addressed.
    always_comb begin
        wr_word = mem_q[beat_q];
        for (int i = 0; i < NB; i++) begin
            if (wb_sel_i[i]) begin
                wr_word[8*i +: 8] = wb_dat_i[8*i +: 8];
            end
        end
    end

    // Read port forwards data being written on the same edge.
    always_comb begin
        if (wr_en && (rd_addr == beat_q)) begin
            rd_word = wr_word;
        end else begin
            rd_word = mem_q[rd_addr];
        end
    end

    assign dat_d = rd_load ? rd_word : dat_q;

    // Next-state, beat pointer and read-load control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        rd_load = 1'b0;
        rd_addr = beat_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (out_of_range) begin
                        state_d = S_ERR;
                    end else begin
                        beat_d = word_idx;
                        if (WAIT_STATES == 0) begin
                            state_d = S_ACK;
                            rd_load = 1'b1;
                            rd_addr = word_idx;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = WS_LOAD;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    rd_load = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                if ((wb_cti_i == CTI_INCR) && req) begin
                    state_d = S_BURST;
                    beat_d  = beat_q + 1'b1;
                    rd_load = 1'b1;
                    rd_addr = beat_q + 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wb_stb_i) begin
                    beat_d  = beat_q + 1'b1;
                    rd_load = 1'b1;
                    rd_addr = beat_q + 1'b1;
                    if (wb_cti_i != CTI_INCR) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and read-data registers; reset aborts any cycle at once.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            beat_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            dat_q   <= dat_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            mem_q[beat_q] <= wr_word;
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: randomized self-checking bench for wb_sram_slave,
// one instance with no wait states and one with three.
module tb_wb_sram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] adr  [2];
    logic [31:0] dati [2];
    logic [31:0] dato [2];
    logic [3:0]  sel  [2];
    logic        we   [2];
    logic        cyc  [2];
    logic        stb  [2];
    logic [2:0]  cti  [2];
    logic        ack  [2];
    logic        err  [2];
    logic        rty  [2];

    wb_sram_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .WAIT_STATES(0)
    ) u_dut0 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wb_adr_i(adr[0]), .wb_dat_i(dati[0]), .wb_dat_o(dato[0]),
        .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_cyc_i(cyc[0]),
        .wb_stb_i(stb[0]), .wb_cti_i(cti[0]), .wb_ack_o(ack[0]),
        .wb_err_o(err[0]), .wb_rty_o(rty[0])
    );

    wb_sram_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .WAIT_STATES(3)
    ) u_dut3 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wb_adr_i(adr[1]), .wb_dat_i(dati[1]), .wb_dat_o(dato[1]),
        .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_cyc_i(cyc[1]),
        .wb_stb_i(stb[1]), .wb_cti_i(cti[1]), .wb_ack_o(ack[1]),
        .wb_err_o(err[1]), .wb_rty_o(rty[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model [2][64];

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // One classic access; reports cycles to termination (0 on timeout).
    task automatic do_classic(input int d, input logic [31:0] a,
                              input logic w, input logic [3:0] s,
                              input logic [31:0] wd, output int lat,
                              output logic [31:0] rd, output logic e,
                              output logic k_ack);
        lat = 0; rd = '0; e = 1'b0; k_ack = 1'b0;
        @(negedge clk);
        adr[d] = a; we[d] = w; sel[d] = s; dati[d] = wd;
        cti[d] = 3'b000; cyc[d] = 1'b1; stb[d] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack[d] || err[d]) begin
                lat = k; e = err[d]; k_ack = ack[d]; rd = dato[d];
                break;
            end
        end
        @(posedge clk); #1;
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rty[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_flags dut%0d: ack=%b err=%b rty=%b, want 0 0 0",
                         d, ack[d], err[d], rty[d]);
            end
            n_cmp++;
            if (dato[d] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_dat dut%0d: got %h want 0", d, dato[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_burst(input int d, input int start, input int n,
                              input bit w, input int stall_at, input bit chk);
        int lat;
        int wi;
        lat = 0;
        @(negedge clk);
        adr[d] = 32'((start % 64) * 4);
        we[d] = w; sel[d] = 4'hF; dati[d] = $urandom;
        cti[d] = (n == 1) ? 3'b111 : 3'b010;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack[d]) begin lat = k; break; end
        end
        n_cmp++;
        if (lat != 1 + ws(d)) begin
            n_bad++;
            $display("FAIL burst_first_lat dut%0d: got %0d cycles want %0d",
                     d, lat, 1 + ws(d));
        end
        if (lat == 0) begin
            cyc[d] = 1'b0; stb[d] = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            wi = (start + i) % 64;
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (ack[d] !== 1'b1 || err[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL burst_ack dut%0d beat %0d: ack=%b err=%b want 1 0",
                         d, i, ack[d], err[d]);
            end
            if (chk) begin
                n_cmp++;
                if (dato[d] !== model[d][wi]) begin
                    n_bad++;
                    $display("FAIL burst_data dut%0d word %0d: got %h want %h",
                             d, wi, dato[d], model[d][wi]);
                end
            end
            if (w) model[d][wi] = dati[d];
            @(posedge clk); #1;
            if (i == stall_at) begin
                stb[d] = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    n_cmp++;
                    if (ack[d] !== 1'b0 ||
                        (chk && dato[d] !== model[d][(wi + 1) % 64])) begin
                        n_bad++;
                        $display("FAIL burst_stall dut%0d: ack=%b dat=%h want 0 %h",
                                 d, ack[d], dato[d], model[d][(wi + 1) % 64]);
                    end
                end
                @(posedge clk); #1;
                stb[d] = 1'b1;
            end
            if (i + 1 < n) begin
                dati[d] = $urandom;
                cti[d] = (i + 2 == n) ? 3'b111 : 3'b010;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; cti[d] = 3'b000;
    endtask

    task automatic test_classic();
        int lat; logic [31:0] rd; logic e, a;
        do_classic(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, lat, rd, e, a);
        model[0][4] = 32'hDEADBEEF;
        n_cmp++;
        if (lat != 1 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL classic_wr_lat: got %0d err=%b want 1 0", lat, e);
        end
        do_classic(0, 32'h10, 1'b0, 4'hF, 32'h0, lat, rd, e, a);
        n_cmp++;
        if (lat != 1 || rd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL classic_rd: lat=%0d dat=%h want 1 deadbeef", lat, rd);
        end
    endtask

    task automatic test_back_to_back(input int d);
        int a1, a2, lat, gap;
        a1 = $urandom_range(0, 63); a2 = $urandom_range(0, 63);
        lat = 0; gap = 0;
        @(negedge clk);
        adr[d] = 32'(a1 * 4); we[d] = 1'b0; sel[d] = 4'hF;
        cti[d] = 3'b000; cyc[d] = 1'b1; stb[d] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack[d]) begin lat = k; break; end
        end
        n_cmp++;
        if (lat != 1 + ws(d) || dato[d] !== model[d][a1]) begin
            n_bad++;
            $display("FAIL b2b_first dut%0d: lat=%0d dat=%h want %0d %h",
                     d, lat, dato[d], 1 + ws(d), model[d][a1]);
        end
        @(posedge clk); #1;
        adr[d] = 32'(a2 * 4);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack[d]) begin gap = k; break; end
        end
        n_cmp++;
        if (gap != 2 + ws(d) || dato[d] !== model[d][a2]) begin
            n_bad++;
            $display("FAIL b2b_second dut%0d: gap=%0d dat=%h want %0d %h",
                     d, gap, dato[d], 2 + ws(d), model[d][a2]);
        end
        @(posedge clk); #1;
        cyc[d] = 1'b0; stb[d] = 1'b0;
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd; logic e, a;
        do_classic(0, 32'h10, 1'b1, 4'b0101, 32'h11223344, lat, rd, e, a);
        model[0][4] = merge(model[0][4], 32'h11223344, 4'b0101);
        do_classic(0, 32'h10, 1'b0, 4'hF, 32'h0, lat, rd, e, a);
        n_cmp++;
        if (rd !== 32'hDE22BE44) begin
            n_bad++;
            $display("FAIL lanes_0101: got %h want de22be44", rd);
        end
        do_classic(0, 32'h10, 1'b1, 4'b0000, $urandom, lat, rd, e, a);
        n_cmp++;
        if (lat != 1 || a !== 1'b1) begin
            n_bad++;
            $display("FAIL lanes_sel0_ack: lat=%0d ack=%b want 1 1", lat, a);
        end
        do_classic(0, 32'h10, 1'b0, 4'hF, 32'h0, lat, rd, e, a);
        n_cmp++;
        if (rd !== 32'hDE22BE44) begin
            n_bad++;
            $display("FAIL lanes_sel0_data: got %h want de22be44", rd);
        end
    endtask

    task automatic test_wait();
        int lat, wa; logic [31:0] rd; logic e, a;
        wa = $urandom_range(0, 63);
        do_classic(1, 32'(wa * 4), 1'b0, 4'hF, 32'h0, lat, rd, e, a);
        n_cmp++;
        if (lat != 4 || rd !== model[1][wa]) begin
            n_bad++;
            $display("FAIL wait_rd: lat=%0d dat=%h want 4 %h", lat, rd, model[1][wa]);
        end
        @(negedge clk);
        adr[1] = 32'(wa * 4); we[1] = 1'b1; sel[1] = 4'hF;
        dati[1] = ~model[1][wa]; cti[1] = 3'b000;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL wait_drop: ack=%b err=%b want 0 0", ack[1], err[1]);
            end
        end
        do_classic(1, 32'(wa * 4), 1'b0, 4'hF, 32'h0, lat, rd, e, a);
        n_cmp++;
        if (lat != 4 || rd !== model[1][wa]) begin
            n_bad++;
            $display("FAIL wait_after_drop: lat=%0d dat=%h want 4 %h",
                     lat, rd, model[1][wa]);
        end
    endtask

    task automatic test_err();
        int lat; logic [31:0] rd; logic e, a;
        logic [31:0] bad [2];
        bad[0] = 32'h0000_0100;
        bad[1] = 32'h8000_0010;
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 2; j++) begin
                do_classic(d, bad[j], 1'b1, 4'hF, $urandom, lat, rd, e, a);
                n_cmp++;
                if (lat != 1 || e !== 1'b1 || a !== 1'b0 || rty[d] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL err_term dut%0d: lat=%0d err=%b ack=%b rty=%b want 1 1 0 0",
                             d, lat, e, a, rty[d]);
                end
                @(negedge clk);
                n_cmp++;
                if (err[d] !== 1'b0 || ack[d] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL err_pulse dut%0d: err=%b ack=%b want 0 0",
                             d, err[d], ack[d]);
                end
            end
            do_classic(d, 32'h0, 1'b0, 4'hF, 32'h0, lat, rd, e, a);
            n_cmp++;
            if (rd !== model[d][0] || e !== 1'b0) begin
                n_bad++;
                $display("FAIL err_nowrite dut%0d: got %h want %h", d, rd, model[d][0]);
            end
        end
    endtask

    task automatic test_random();
        int d, wa, lat; logic w; logic [3:0] s; logic [31:0] wd, rd;
        logic e, a;
        for (int it = 0; it < 60; it++) begin
            d = $urandom_range(0, 1);
            wa = $urandom_range(0, 63);
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom);
            wd = $urandom;
            do_classic(d, 32'(wa * 4) | 32'($urandom_range(0, 3)),
                       w, s, wd, lat, rd, e, a);
            n_cmp++;
            if (lat != 1 + ws(d) || e !== 1'b0 || a !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_lat dut%0d: lat=%0d err=%b want %0d 0",
                         d, lat, e, 1 + ws(d));
            end
            if (w) begin
                model[d][wa] = merge(model[d][wa], wd, s);
            end else begin
                n_cmp++;
                if (rd !== model[d][wa]) begin
                    n_bad++;
                    $display("FAIL rand_rd dut%0d word %0d: got %h want %h",
                             d, wa, rd, model[d][wa]);
                end
            end
        end
    endtask

    task automatic test_reset_midburst();
        int wa, lat; logic [31:0] rd; logic e, a;
        wa = $urandom_range(0, 63);
        lat = 0;
        @(negedge clk);
        adr[0] = 32'(wa * 4); we[0] = 1'b0; sel[0] = 4'hF;
        cti[0] = 3'b010; cyc[0] = 1'b1; stb[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack[0]) begin lat = k; break; end
        end
        @(negedge clk);
        n_cmp++;
        if (lat != 1 || ack[0] !== 1'b1 || dato[0] !== model[0][(wa + 1) % 64]) begin
            n_bad++;
            $display("FAIL rstb_pre: lat=%0d ack=%b dat=%h want 1 1 %h",
                     lat, ack[0], dato[0], model[0][(wa + 1) % 64]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ack[0] !== 1'b0 || err[0] !== 1'b0 || dato[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL rstb_async: ack=%b err=%b dat=%h want 0 0 0",
                     ack[0], err[0], dato[0]);
        end
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0; cti[0] = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) wa = $urandom_range(0, 63);
            do_classic(0, 32'(wa * 4), 1'b0, 4'hF, 32'h0, lat, rd, e, a);
            n_cmp++;
            if (lat != 1 || rd !== model[0][wa]) begin
                n_bad++;
                $display("FAIL rstb_after: lat=%0d dat=%h want 1 %h",
                         lat, rd, model[0][wa]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            adr[d] = '0; dati[d] = '0; sel[d] = '0; we[d] = 1'b0;
            cyc[d] = 1'b0; stb[d] = 1'b0; cti[d] = 3'b000;
        end
        test_reset();
        test_burst(0, 0, 64, 1'b1, -1, 1'b0);
        test_burst(1, 0, 64, 1'b1, -1, 1'b0);
        test_classic();
        test_back_to_back(0);
        test_back_to_back(1);
        test_byte_lanes();
        test_wait();
        test_err();
        test_burst(0, 62, 8, 1'b1, -1, 1'b1);
        test_burst(0, 62, 8, 1'b0, 3, 1'b1);
        test_burst(1, 62, 8, 1'b1, 2, 1'b1);
        test_burst(1, 62, 8, 1'b0, 4, 1'b1);
        test_burst(0, $urandom_range(0, 63), 5, 1'b1, 1, 1'b1);
        test_random();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
